keypad_hex_entry: RTL and testbench

Parametrised keypad-to-hex-value entry buffer. It turns strobed 4x4 keypad presses into a left-justified, DIGITS-nibble value. It supports backspace, explicit or automatic commit, and a valid/ack handshake toward the consumer. It sits between the keypad debouncer/scanner and colour/parameter registers, and generalises the fixed 6-digit colour entry to any width.

---
 rtl/keypad_hex_entry.sv | 147 ++++++++++++++
 tb/tb_keypad_hex_entry.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_hex_entry.sv
// Keypad hex entry buffer: collects DIGITS left-justified nibbles from
// strobed 4x4 keypad presses and offers the committed value through valid/ack.
module keypad_hex_entry #(
  parameter int DIGITS      = 6,
  parameter int AUTO_COMMIT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          button_pressed,
  input  logic [1:0]                    row,
  input  logic [1:0]                    col,
  input  logic                          ack,
  output logic [4*DIGITS-1:0]           entry,
  output logic [$clog2(DIGITS+1)-1:0]   count,
  output logic [4*DIGITS-1:0]           value,
  output logic                          valid,
  output logic                          full,
  output logic                          key_rejected
);

  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] ZERO  = '0;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] LAST  = CW'(DIGITS-1);
  localparam logic [CW-1:0] FULLV = CW'(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    FULL,
    HOLD
  } state_t;

  state_t state;

  logic [3:0]          nib;
  logic                is_bs;
  logic                is_commit;
  logic                is_digit;
  logic [4*DIGITS-1:0] wr_entry;
  logic [4*DIGITS-1:0] bs_entry;

  always_comb begin
    nib = 4'h0;
    unique case ({row, col})
      4'h0: nib = 4'h1;
      4'h1: nib = 4'h2;
      4'h2: nib = 4'h3;
      4'h3: nib = 4'hA;
      4'h4: nib = 4'h4;
      4'h5: nib = 4'h5;
      4'h6: nib = 4'h6;
      4'h7: nib = 4'hB;
      4'h8: nib = 4'h7;
      4'h9: nib = 4'h8;
      4'hA: nib = 4'h9;
      4'hB: nib = 4'hC;
      4'hC: nib = 4'h0;
      4'hD: nib = 4'h0;
      4'hE: nib = 4'h0;
      4'hF: nib = 4'hD;
    endcase
  end

  assign is_bs     = ({row, col} == 4'hC);
  assign is_commit = ({row, col} == 4'hE);
  assign is_digit  = !is_bs && !is_commit;

  // New digit lands at DIGITS-1-count; backspace clears DIGITS-count.
  always_comb begin
    wr_entry = entry;
    bs_entry = entry;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == DIGITS - 1 - int'(count))
        wr_entry[4*i +: 4] = nib;
      if (i == DIGITS - int'(count))
        bs_entry[4*i +: 4] = 4'h0;
    end
  end

  assign full = (count == FULLV);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      entry        <= '0;
      count        <= '0;
      value        <= '0;
      valid        <= 1'b0;
      key_rejected <= 1'b0;
    end else begin
      key_rejected <= 1'b0;
      unique case (state)
        IDLE, ENTRY, FULL: begin
          if (button_pressed) begin
            if (is_digit) begin
              if (count == FULLV) begin
                key_rejected <= 1'b1;
              end else begin
                entry <= wr_entry;
                count <= count + ONE;
                if (count == LAST) begin
                  if (AUTO_COMMIT != 0) begin
                    value <= wr_entry;
                    valid <= 1'b1;
                    state <= HOLD;
                  end else begin
                    state <= FULL;
                  end
                end else begin
                  state <= ENTRY;
                end
              end
            end else if (is_bs) begin
              if (count == ZERO) begin
                key_rejected <= 1'b1;
              end else begin
                entry <= bs_entry;
                count <= count - ONE;
                state <= (count == ONE) ? IDLE : ENTRY;
              end
            end else begin
              if (count == ZERO) begin
                key_rejected <= 1'b1;
              end else begin
                value <= entry;
                valid <= 1'b1;
                state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (button_pressed)
            key_rejected <= 1'b1;
          if (ack) begin
            valid <= 1'b0;
            entry <= '0;
            count <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry: auto-commit (6 digits), manual
// commit (6 and 4 digits), backspace, hold/ack and reset behaviour.
module tb_keypad_hex_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button_pressed = 1'b0;
  logic [1:0] row = 2'd0;
  logic [1:0] col = 2'd0;
  logic       ack = 1'b0;

  logic [23:0] entry_a, value_a;
  logic [2:0]  count_a;
  logic        valid_a, full_a, rej_a;

  logic [23:0] entry_b, value_b;
  logic [2:0]  count_b;
  logic        valid_b, full_b, rej_b;

  logic [15:0] entry_c, value_c;
  logic [2:0]  count_c;
  logic        valid_c, full_c, rej_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_hex_entry #(.DIGITS(6), .AUTO_COMMIT(1)) u_a (
    .clk(clk), .reset(reset), .button_pressed(button_pressed),
    .row(row), .col(col), .ack(ack),
    .entry(entry_a), .count(count_a), .value(value_a),
    .valid(valid_a), .full(full_a), .key_rejected(rej_a)
  );

  keypad_hex_entry #(.DIGITS(6), .AUTO_COMMIT(0)) u_b (
    .clk(clk), .reset(reset), .button_pressed(button_pressed),
    .row(row), .col(col), .ack(ack),
    .entry(entry_b), .count(count_b), .value(value_b),
    .valid(valid_b), .full(full_b), .key_rejected(rej_b)
  );

  keypad_hex_entry #(.DIGITS(4), .AUTO_COMMIT(0)) u_c (
    .clk(clk), .reset(reset), .button_pressed(button_pressed),
    .row(row), .col(col), .ack(ack),
    .entry(entry_c), .count(count_c), .value(value_c),
    .valid(valid_c), .full(full_c), .key_rejected(rej_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    row = r;
    col = c;
    button_pressed = 1'b1;
    @(posedge clk);
    #1;
    button_pressed = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    do_reset();
    chk("rst_entry", 32'(entry_a), 32'h0);
    chk("rst_count", 32'(count_a), 32'h0);
    chk("rst_value", 32'(value_a), 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_full", 32'(full_a), 32'h0);
    chk("rst_rej", 32'(rej_a), 32'h0);

    // auto-commit sequence: C 5 A 0 D 8
    press(2'd2, 2'd3);
    chk("a_entry1", 32'(entry_a), 32'h00C00000);
    chk("a_count1", 32'(count_a), 32'd1);
    chk("a_rej1", 32'(rej_a), 32'h0);
    press(2'd1, 2'd1);
    chk("a_entry2", 32'(entry_a), 32'h00C50000);
    press(2'd0, 2'd3);
    chk("a_entry3", 32'(entry_a), 32'h00C5A000);
    press(2'd3, 2'd1);
    chk("a_entry4", 32'(entry_a), 32'h00C5A000);
    chk("a_count4", 32'(count_a), 32'd4);
    press(2'd3, 2'd3);
    chk("a_entry5", 32'(entry_a), 32'h00C5A0D0);
    chk("a_valid5", 32'(valid_a), 32'h0);
    press(2'd2, 2'd1);
    chk("a_value", 32'(value_a), 32'h00C5A0D8);
    chk("a_valid", 32'(valid_a), 32'h1);
    chk("a_count6", 32'(count_a), 32'd6);
    chk("a_full6", 32'(full_a), 32'h1);

    // press 7 during hold
    press(2'd2, 2'd0);
    chk("hold_rej", 32'(rej_a), 32'h1);
    chk("hold_value", 32'(value_a), 32'h00C5A0D8);
    chk("hold_valid", 32'(valid_a), 32'h1);

    // ack together with press 9
    ack = 1'b1;
    press(2'd2, 2'd2);
    ack = 1'b0;
    chk("ackp_valid", 32'(valid_a), 32'h0);
    chk("ackp_count", 32'(count_a), 32'h0);
    chk("ackp_entry", 32'(entry_a), 32'h0);
    chk("ackp_rej", 32'(rej_a), 32'h1);
    chk("ackp_value", 32'(value_a), 32'h00C5A0D8);

    // backspace
    press(2'd2, 2'd3);
    press(2'd1, 2'd1);
    press(2'd3, 2'd0);
    chk("bs_entry1", 32'(entry_a), 32'h00C00000);
    chk("bs_count1", 32'(count_a), 32'd1);
    press(2'd3, 2'd0);
    chk("bs_entry0", 32'(entry_a), 32'h0);
    chk("bs_count0", 32'(count_a), 32'h0);
    chk("bs_rej0", 32'(rej_a), 32'h0);
    press(2'd3, 2'd0);
    chk("bs_rej_empty", 32'(rej_a), 32'h1);
    chk("bs_count_e", 32'(count_a), 32'h0);

    // 4 digits, manual commit: 1 2 3 4 5 #
    do_reset();
    press(2'd0, 2'd0);
    press(2'd0, 2'd1);
    press(2'd0, 2'd2);
    chk("c_full3", 32'(full_c), 32'h0);
    press(2'd1, 2'd0);
    chk("c_full", 32'(full_c), 32'h1);
    chk("c_entry", 32'(entry_c), 32'h00001234);
    chk("c_valid4", 32'(valid_c), 32'h0);
    press(2'd1, 2'd1);
    chk("c_rej5", 32'(rej_c), 32'h1);
    chk("c_entry5", 32'(entry_c), 32'h00001234);
    press(2'd3, 2'd2);
    chk("c_value", 32'(value_c), 32'h00001234);
    chk("c_valid", 32'(valid_c), 32'h1);

    // partial commit, 6 digits manual: A B #
    do_reset();
    press(2'd0, 2'd3);
    press(2'd1, 2'd3);
    press(2'd3, 2'd2);
    chk("b_value", 32'(value_b), 32'h00AB0000);
    chk("b_valid", 32'(valid_b), 32'h1);
    chk("b_full", 32'(full_b), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("b_valid_stay", 32'(valid_b), 32'h1);
    do_ack();
    chk("b_ack_valid", 32'(valid_b), 32'h0);
    chk("b_ack_value", 32'(value_b), 32'h00AB0000);
    press(2'd3, 2'd2);
    chk("b_empty_commit", 32'(rej_b), 32'h1);
    chk("b_valid_after", 32'(valid_b), 32'h0);

    // reset mid-entry after 3 digits
    press(2'd0, 2'd0);
    press(2'd0, 2'd1);
    press(2'd0, 2'd2);
    chk("b_entry3", 32'(entry_b), 32'h00123000);
    do_reset();
    chk("mr_entry", 32'(entry_b), 32'h0);
    chk("mr_count", 32'(count_b), 32'h0);
    chk("mr_valid", 32'(valid_b), 32'h0);
    chk("mr_value", 32'(value_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
